// File: rtl/nano_ifetch_pkg.sv
// Shared constants, FSM encodings and buffer payload for the nano_ifetch fetch unit.
package nano_ifetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } fetch_entry_t;

  // Fetch addresses are always word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/nano_ifetch_if.sv
// Fetch-unit bus bundle: imem request/response, instruction channel to the core, redirect.
interface nano_ifetch_if;
  import nano_ifetch_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output req_valid, req_addr, inst_valid, inst, inst_pc,
    input  req_ready, rsp_valid, rsp_data, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  req_valid, req_addr, inst_valid, inst, inst_pc,
    output req_ready, rsp_valid, rsp_data, inst_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/nano_ifetch_sync_fifo.sv
// Small synchronous FIFO with registered head, synchronous flush and occupancy count.
module nano_ifetch_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/nano_ifetch.sv
// Instruction fetch unit: credit-limited word fetches, in-order response buffering, redirect flush.
module nano_ifetch
  import nano_ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input logic           clk,
  input logic           rst_n,
  nano_ifetch_if.master bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = CW + 2;

  logic [1:0]      state_q, state_n;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_n;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_n;
  logic [CW-1:0]   outstanding_q, outstanding_n;
  logic [CW-1:0]   discard_q, discard_n;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            push, pop, accept, drop, req_valid_c;
  logic [SW-1:0]   credit_used;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_BOOT;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_n;
      fetch_pc_q    <= fetch_pc_n;
      rsp_pc_q      <= rsp_pc_n;
      outstanding_q <= outstanding_n;
      discard_q     <= discard_n;
    end
  end

  always_comb begin
    state_n       = state_q;
    fetch_pc_n    = fetch_pc_q;
    rsp_pc_n      = rsp_pc_q;
    outstanding_n = outstanding_q;
    discard_n     = discard_q;

    // Every slot in flight or buffered costs one credit; a pop this cycle frees one.
    pop         = !fifo_empty && bus.inst_ready;
    credit_used = SW'(outstanding_q) + SW'(discard_q) + SW'(fifo_count) - SW'(pop);
    req_valid_c = (state_q != S_BOOT) && !bus.redirect && (credit_used < SW'(FIFO_DEPTH));
    accept      = req_valid_c && bus.req_ready;

    // Responses to pre-redirect requests are always the oldest, so they drain first.
    drop       = bus.rsp_valid && (discard_q != '0);
    push       = bus.rsp_valid && !drop && !bus.redirect;
    push_entry = '{pc: rsp_pc_q, data: bus.rsp_data};

    if (accept) fetch_pc_n = fetch_pc_q + XLEN'(4);

    if (bus.redirect) begin
      fetch_pc_n    = word_align(bus.redirect_pc);
      rsp_pc_n      = word_align(bus.redirect_pc);
      outstanding_n = '0;
      discard_n     = CW'(SW'(discard_q) + SW'(outstanding_q) + SW'(accept) - SW'(bus.rsp_valid));
    end else begin
      if (push) rsp_pc_n = rsp_pc_q + XLEN'(4);
      outstanding_n = outstanding_q + CW'(accept) - CW'(bus.rsp_valid && !drop);
      if (drop) discard_n = discard_q - CW'(1);
    end

    case (state_q)
      S_BOOT:  state_n = S_FETCH;
      S_FETCH: if (bus.redirect && (discard_n != '0)) state_n = S_DRAIN;
      S_DRAIN: if (discard_n == '0) state_n = S_FETCH;
      default: state_n = S_BOOT;
    endcase
  end

  nano_ifetch_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .wdata (push_entry),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign bus.req_valid  = req_valid_c;
  assign bus.req_addr   = fetch_pc_q;
  assign bus.inst_valid = !fifo_empty;
  assign bus.inst       = fifo_empty ? INST_NOP : head.data;
  assign bus.inst_pc    = fifo_empty ? '0 : head.pc;

  // A response with nothing in flight means the memory broke the protocol.
  always_ff @(posedge clk) begin
    if (rst_n && bus.rsp_valid) begin
      assert ((outstanding_q != '0) || (discard_q != '0))
        else $error("nano_ifetch: response with no fetch in flight");
    end
  end

endmodule
